// File: rtl/code8b10b_pkg.sv
// Shared 8b/10b constants used by both the encoder and the decoder.
package code8b10b_pkg;

    localparam logic RD_MINUS = 1'b0;
    localparam logic RD_PLUS  = 1'b1;

    localparam logic [7:0] K28_5 = 8'hBC;

    // K28.0..K28.7, then K23.7, K27.7, K29.7, K30.7
    localparam int NUM_LEGAL_K = 12;
    localparam logic [NUM_LEGAL_K-1:0][7:0] LEGAL_K = {
        8'h1C, 8'h3C, 8'h5C, 8'h7C, 8'h9C, K28_5, 8'hDC, 8'hFC,
        8'hF7, 8'hFB, 8'hFD, 8'hFE
    };

    function automatic logic is_legal_k(input logic [7:0] b);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < NUM_LEGAL_K; i++) begin
            hit = hit | (LEGAL_K[i] == b);
        end
        return hit;
    endfunction

endpackage

// File: rtl/encode_lookup.sv
// Combinational 8b/10b lookup: 5b/6b and 3b/4b sub-blocks with running-disparity tracking.
module encode_lookup
    import code8b10b_pkg::*;
(
    input  logic [7:0] data8_i,
    input  logic       k_i,
    input  logic       rd_i,
    output logic [9:0] data10_o,
    output logic       rd_o,
    output logic       kerr_o
);

    logic [4:0] x;
    logic [2:0] y;
    logic       k_ok;
    logic [5:0] tbl6;
    logic [5:0] sb6;
    logic [3:0] tbl4;
    logic [3:0] sb4;
    logic       unbal6;
    logic       unbal4;
    logic       rd6;
    logic       alt7;

    // Tables hold the RD- form (abcdei / fghj, a and f in the MSB)
    always_comb begin
        x = data8_i[4:0];
        y = data8_i[7:5];
        k_ok = k_i && is_legal_k(data8_i);
        kerr_o = k_i && !k_ok;

        case (x)
            5'd0:  tbl6 = 6'b100111;
            5'd1:  tbl6 = 6'b011101;
            5'd2:  tbl6 = 6'b101101;
            5'd3:  tbl6 = 6'b110001;
            5'd4:  tbl6 = 6'b110101;
            5'd5:  tbl6 = 6'b101001;
            5'd6:  tbl6 = 6'b011001;
            5'd7:  tbl6 = 6'b111000;
            5'd8:  tbl6 = 6'b111001;
            5'd9:  tbl6 = 6'b100101;
            5'd10: tbl6 = 6'b010101;
            5'd11: tbl6 = 6'b110100;
            5'd12: tbl6 = 6'b001101;
            5'd13: tbl6 = 6'b101100;
            5'd14: tbl6 = 6'b011100;
            5'd15: tbl6 = 6'b010111;
            5'd16: tbl6 = 6'b011011;
            5'd17: tbl6 = 6'b100011;
            5'd18: tbl6 = 6'b010011;
            5'd19: tbl6 = 6'b110010;
            5'd20: tbl6 = 6'b001011;
            5'd21: tbl6 = 6'b101010;
            5'd22: tbl6 = 6'b011010;
            5'd23: tbl6 = 6'b111010;
            5'd24: tbl6 = 6'b110011;
            5'd25: tbl6 = 6'b100110;
            5'd26: tbl6 = 6'b010110;
            5'd27: tbl6 = 6'b110110;
            5'd28: tbl6 = k_ok ? 6'b001111 : 6'b001110;
            5'd29: tbl6 = 6'b101110;
            5'd30: tbl6 = 6'b011110;
            default: tbl6 = 6'b101011;
        endcase

        unbal6 = $countones(tbl6) != 3;
        sb6 = (rd_i == RD_PLUS && (unbal6 || x == 5'd7)) ? ~tbl6 : tbl6;
        rd6 = unbal6 ? ~rd_i : rd_i;

        // Alternate A7 avoids a run of five equal bits across the sub-block boundary
        alt7 = k_ok || ((rd6 == RD_PLUS) ? (x == 5'd11 || x == 5'd13 || x == 5'd14)
                                         : (x == 5'd17 || x == 5'd18 || x == 5'd20));

        case (y)
            3'd0:    tbl4 = 4'b1011;
            3'd1:    tbl4 = 4'b1001;
            3'd2:    tbl4 = 4'b0101;
            3'd3:    tbl4 = 4'b1100;
            3'd4:    tbl4 = 4'b1101;
            3'd5:    tbl4 = 4'b1010;
            3'd6:    tbl4 = 4'b0110;
            default: tbl4 = alt7 ? 4'b0111 : 4'b1110;
        endcase

        unbal4 = $countones(tbl4) != 2;
        // K28 neutral 3b/4b codes are the complement of the data forms at RD-
        if (unbal4 || y == 3'd3) begin
            sb4 = (rd6 == RD_PLUS) ? ~tbl4 : tbl4;
        end else if (k_ok) begin
            sb4 = (rd6 == RD_PLUS) ? tbl4 : ~tbl4;
        end else begin
            sb4 = tbl4;
        end
        rd_o = unbal4 ? ~rd6 : rd6;

        data10_o = {sb4[0], sb4[1], sb4[2], sb4[3],
                    sb6[0], sb6[1], sb6[2], sb6[3], sb6[4], sb6[5]};
    end

endmodule

// File: rtl/encoder_8b10b.sv
// Registered 8b/10b encoder with valid/ready handshake and running-disparity state.
// Define ENC8B10B_FORCE_DISP_EN to add i_force_disp/i_disp_val starting-disparity override.
module encoder_8b10b
    import code8b10b_pkg::*;
#(
    parameter logic RD_INIT = RD_MINUS
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_valid,
    output logic       o_ready,
    input  logic [7:0] i_data8,
    input  logic       i_k,
`ifdef ENC8B10B_FORCE_DISP_EN
    input  logic       i_force_disp,
    input  logic       i_disp_val,
`endif
    output logic       o_valid,
    input  logic       i_ready,
    output logic [9:0] o_data10,
    output logic       o_kerr,
    output logic       o_run_disp
);

    logic       valid_q;
    logic [9:0] data_q;
    logic       kerr_q;
    logic       rd_q;
    logic       start_rd;
    logic       accept;
    logic [9:0] code;
    logic       end_rd;
    logic       kerr;

    assign o_ready = !valid_q || i_ready;
    assign accept  = i_valid && o_ready;

`ifdef ENC8B10B_FORCE_DISP_EN
    assign start_rd = i_force_disp ? i_disp_val : rd_q;
`else
    assign start_rd = rd_q;
`endif

    encode_lookup u_lookup (
        .data8_i  (i_data8),
        .k_i      (i_k),
        .rd_i     (start_rd),
        .data10_o (code),
        .rd_o     (end_rd),
        .kerr_o   (kerr)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            valid_q <= 1'b0;
            data_q  <= 10'h000;
            kerr_q  <= 1'b0;
            rd_q    <= RD_INIT;
        end else if (accept) begin
            valid_q <= 1'b1;
            data_q  <= code;
            kerr_q  <= kerr;
            rd_q    <= end_rd;
        end else if (i_ready) begin
            valid_q <= 1'b0;
        end
    end

    assign o_valid    = valid_q;
    assign o_data10   = data_q;
    assign o_kerr     = kerr_q;
    assign o_run_disp = rd_q;

endmodule

// File: tb/tb_encoder_8b10b.sv
// Directed self-checking bench for encoder_8b10b.
module tb_encoder_8b10b;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       out_ready;
    logic [7:0] data8;
    logic       k;
    logic       out_valid;
    logic       ds_ready;
    logic [9:0] data10;
    logic       kerr;
    logic       run_disp;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    encoder_8b10b #(.RD_INIT(1'b0)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_valid      (in_valid),
        .o_ready      (out_ready),
        .i_data8      (data8),
        .i_k          (k),
`ifdef ENC8B10B_FORCE_DISP_EN
        .i_force_disp (1'b0),
        .i_disp_val   (1'b0),
`endif
        .o_valid      (out_valid),
        .i_ready      (ds_ready),
        .o_data10     (data10),
        .o_kerr       (kerr),
        .o_run_disp   (run_disp)
    );

    task automatic check_eq(input string tag, input logic [9:0] got, input logic [9:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Present one byte for a single cycle; outputs are sampled on the following falling edge
    task automatic send(input logic [7:0] b, input logic kk);
        in_valid = 1'b1;
        data8    = b;
        k        = kk;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic expect_word(input string tag, input logic [9:0] w, input logic rd,
                               input logic ke);
        check_eq({tag, " valid"}, 10'(out_valid), 10'd1);
        check_eq({tag, " data"}, data10, w);
        check_eq({tag, " rd"}, 10'(run_disp), 10'(rd));
        check_eq({tag, " kerr"}, 10'(kerr), 10'(ke));
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        data8    = 8'h00;
        k        = 1'b0;
        ds_ready = 1'b1;
        repeat (2) @(negedge clk);
        check_eq("reset valid", 10'(out_valid), 10'd0);
        check_eq("reset data", data10, 10'h000);
        check_eq("reset kerr", 10'(kerr), 10'd0);
        check_eq("reset rd", 10'(run_disp), 10'd0);
        rst = 1'b0;
        @(negedge clk);
        check_eq("reset ready", 10'(out_ready), 10'd1);

        send(8'hBC, 1'b1); expect_word("K28.5 rd-", 10'h17C, 1'b1, 1'b0);
        send(8'hBC, 1'b1); expect_word("K28.5 rd+", 10'h283, 1'b0, 1'b0);
        send(8'hB5, 1'b0); expect_word("D21.5", 10'h155, 1'b0, 1'b0);
        send(8'hF1, 1'b0); expect_word("D17.7 A7", 10'h3B1, 1'b1, 1'b0);
        send(8'hBC, 1'b1); expect_word("K28.5 back", 10'h283, 1'b0, 1'b0);
        send(8'h00, 1'b1); expect_word("illegal K", 10'h0B9, 1'b0, 1'b1);
        send(8'hB5, 1'b0); expect_word("after kerr", 10'h155, 1'b0, 1'b0);
        send(8'hF1, 1'b0); expect_word("D17.7 again", 10'h3B1, 1'b1, 1'b0);
        send(8'hEB, 1'b0); expect_word("D11.7 A7 rd+", 10'h04B, 1'b0, 1'b0);
        send(8'hFC, 1'b1); expect_word("K28.7", 10'h07C, 1'b0, 1'b0);

        // Stall with a pending byte; the held word must not change
        ds_ready = 1'b0;
        in_valid = 1'b1;
        data8    = 8'hBC;
        k        = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("stall data", data10, 10'h07C);
            check_eq("stall ready", 10'(out_ready), 10'd0);
            check_eq("stall rd", 10'(run_disp), 10'd0);
            check_eq("stall valid", 10'(out_valid), 10'd1);
        end
        ds_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        expect_word("after stall", 10'h17C, 1'b1, 1'b0);

        // Reset mid-stream drops the byte offered in the same cycle
        in_valid = 1'b1;
        data8    = 8'hB5;
        k        = 1'b0;
        rst      = 1'b1;
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        check_eq("midrst valid", 10'(out_valid), 10'd0);
        check_eq("midrst rd", 10'(run_disp), 10'd0);
        check_eq("midrst data", data10, 10'h000);
        check_eq("midrst kerr", 10'(kerr), 10'd0);
        check_eq("midrst ready", 10'(out_ready), 10'd1);
        @(negedge clk);
        check_eq("dropped byte", 10'(out_valid), 10'd0);

        // Back-to-back acceptance, one word per cycle
        in_valid = 1'b1;
        data8    = 8'hB5;
        k        = 1'b0;
        @(negedge clk);
        expect_word("b2b first", 10'h155, 1'b0, 1'b0);
        data8 = 8'hBC;
        k     = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        expect_word("b2b second", 10'h17C, 1'b1, 1'b0);
        @(negedge clk);
        check_eq("drain valid", 10'(out_valid), 10'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
